scoreboard_display_scheduler: RTL

Time-multiplexes N score/timer channels onto one shared display bus for the basketball scoreboard. It replaces the purely combinational score/timer selector with a clocked scheduler. Score channels are scanned round-robin at a refresh slot rate, then the timer channel is shown as an overlay for a programmable number of slots. Each channel value is snapshotted at a slot boundary, so the displayed value never tears mid-slot.

---
 rtl/scoreboard_display_pkg.sv | 15 +
 rtl/scoreboard_display_scheduler_slot_timer.sv | 30 +++
 rtl/scoreboard_display_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/scoreboard_display_pkg.sv
// Shared types and constants for the scoreboard display scheduler.
package scoreboard_display_pkg;

    // Scheduler states: idle until first enable, round-robin scan, timer overlay.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OVL  = 2'd2
    } state_t;

    // Encoding of the phase output.
    localparam logic PH_SCAN = 1'b0;
    localparam logic PH_OVL  = 1'b1;

endpackage

// File: rtl/scoreboard_display_scheduler_slot_timer.sv
// Slot prescaler: counts enabled cycles and flags the last cycle of each slot.
module slot_timer #(
    parameter int SLOT_CYC = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic boundary
);

    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    logic [CNT_W-1:0] slot_cnt;

    // Combinational so the scheduler can act on the boundary in the same cycle.
    assign boundary = enable && (slot_cnt == CNT_W'(SLOT_CYC - 1));

    // Advance the in-slot counter on enabled cycles, wrapping at the boundary.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            slot_cnt <= '0;
        end else if (enable) begin
            if (boundary) slot_cnt <= '0;
            else          slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scoreboard_display_scheduler.sv
// Time-multiplexes score channels and a timer overlay onto one display bus.
// Each slot's value is snapshotted at the slot boundary so it never tears.
module scoreboard_display_scheduler
    import scoreboard_display_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int W          = 7,
    parameter int OVL_W      = 5,
    parameter int SLOT_CYC   = 4,
    parameter int SCAN_SLOTS = 4,
    parameter int OVL_SLOTS  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic              force_ovl,
    output logic [W-1:0]      saida,
    output logic [N_CH-1:0]   sel,
    output logic              phase,
    output logic              slot_start
);

    localparam int IDX_W  = (N_CH > 2) ? $clog2(N_CH - 1) : 1;
    localparam int PS_MAX = (SCAN_SLOTS > OVL_SLOTS) ? SCAN_SLOTS : OVL_SLOTS;
    localparam int PS_W   = (PS_MAX > 1) ? $clog2(PS_MAX) : 1;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [PS_W-1:0]   phase_slots, phase_slots_nxt;
    logic [W-1:0]      saida_nxt;
    logic [N_CH-1:0]   sel_nxt;
    logic              phase_nxt;
    logic              slot_start_nxt;
    logic              load;
    logic              boundary;
    logic [W-1:0]      ovl_word;

    // The slot counter only runs once the scheduler has left IDLE.
    slot_timer #(.SLOT_CYC(SLOT_CYC)) u_slot_timer (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable && (state != IDLE)),
        .boundary (boundary)
    );

    // Next-state, counter and snapshot decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt       = state;
        idx_nxt         = idx;
        phase_slots_nxt = phase_slots;
        saida_nxt       = saida;
        sel_nxt         = sel;
        phase_nxt       = phase;
        slot_start_nxt  = 1'b0;
        load            = 1'b0;

        ovl_word                = '0;
        ovl_word[OVL_W-1:0]     = ch_data[(N_CH-1)*W +: OVL_W];

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt       = SCAN;
                    idx_nxt         = '0;
                    phase_slots_nxt = '0;
                    load            = 1'b1;
                end
            end
            SCAN: begin
                if (boundary) begin
                    load = 1'b1;
                    if (phase_slots == PS_W'(SCAN_SLOTS - 1) || force_ovl) begin
                        state_nxt       = OVL;
                        phase_slots_nxt = '0;
                    end else begin
                        idx_nxt         = (idx == IDX_W'(N_CH - 2)) ? '0 : idx + IDX_W'(1);
                        phase_slots_nxt = phase_slots + PS_W'(1);
                    end
                end
            end
            OVL: begin
                if (boundary) begin
                    load = 1'b1;
                    if (phase_slots == PS_W'(OVL_SLOTS - 1)) begin
                        // A held force keeps the overlay; the count saturates here.
                        if (!force_ovl) begin
                            state_nxt       = SCAN;
                            idx_nxt         = '0;
                            phase_slots_nxt = '0;
                        end
                    end else begin
                        phase_slots_nxt = phase_slots + PS_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Snapshot the upcoming slot's channel and decode its select.
        if (load) begin
            slot_start_nxt = 1'b1;
            sel_nxt        = '0;
            if (state_nxt == OVL) begin
                saida_nxt          = ovl_word;
                sel_nxt[N_CH-1]    = 1'b1;
                phase_nxt          = PH_OVL;
            end else begin
                saida_nxt          = ch_data[int'(idx_nxt)*W +: W];
                sel_nxt[idx_nxt]   = 1'b1;
                phase_nxt          = PH_SCAN;
            end
        end
    end

    // State, counters and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            phase_slots <= '0;
            saida       <= '0;
            sel         <= '0;
            phase       <= PH_SCAN;
            slot_start  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            phase_slots <= phase_slots_nxt;
            saida       <= saida_nxt;
            sel         <= sel_nxt;
            phase       <= phase_nxt;
            slot_start  <= slot_start_nxt;
        end
    end

endmodule
